// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues word-aligned fetch requests under a credit limit, buffers in-order
// responses with their PCs in a small FIFO, and handles redirects by flushing
// the buffer and discarding responses to requests already in flight.
// Optional build macro: FETCH_MISALIGN_CHECK_EN enables the sticky
// fetch_misaligned flag for redirect targets with nonzero low bits.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_misaligned
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = FIFO_DEPTH[CNT_W:0];

  logic [31:0]      fetch_pc;
  logic [31:0]      rsp_pc;
  logic [31:0]      target_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard_cnt;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_sum;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem   [FIFO_DEPTH];

  logic req_fire;
  logic rsp_drop;
  logic push;
  logic pop;

  // Handshake qualifiers, credit check and FIFO head outputs.
  always_comb begin
    // NOTE: every always_comb output gets an unconditional assignment first so no path can infer a latch.
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    credit_sum     = {1'b0, count} + {1'b0, outstanding};
    target_pc      = {redirect_pc[31:2], 2'b00};
    if (!reset) begin
      imem_req_valid = (credit_sum < DEPTH_V) && !redirect_valid;
      instr_valid    = (count != '0) && !redirect_valid;
    end
    imem_req_addr = {fetch_pc[31:2], 2'b00};
    req_fire      = imem_req_valid && imem_req_ready;
    // A response is stale if it lands in a redirect cycle or while older requests are still being drained.
    rsp_drop      = redirect_valid || (discard_cnt != '0);
    push          = imem_rsp_valid && !rsp_drop;
    pop           = instr_valid && instr_ready;
    instr         = data_mem[rd_ptr];
    instr_pc      = pc_mem[rd_ptr];
  end

  // Fetch and response PCs: reload on redirect, otherwise step per transfer / accepted response.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= target_pc;
      rsp_pc   <= target_pc;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (push)     rsp_pc   <= rsp_pc + 32'd4;
    end
  end

  // In-flight request count: up per accepted request, down per returning response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stale-response counter: loaded with everything still in flight at a redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      discard_cnt <= outstanding - CNT_W'(imem_rsp_valid);
    end else if (imem_rsp_valid && (discard_cnt != '0)) begin
      discard_cnt <= discard_cnt - CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: instruction word and its PC written together on push.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; count and pointers alone decide which entries are valid.
    if (push) begin
      data_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky flag for redirect targets that are not word aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_misaligned <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fetch_misaligned <= 1'b1;
    end
  end
`else
  logic misalign_bits_unused;
  assign misalign_bits_unused = ^redirect_pc[1:0];
  assign fetch_misaligned     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with an in-order memory
// model (1-cycle latency, responses can be held back to build up in-flight requests).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;
  logic        mem_hold;

  int checks   = 0;
  int failures = 0;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MIS_EXP = 1'b1;
`else
  localparam logic MIS_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // In-order memory model; presents the oldest pending request one cycle after it is accepted.
  logic [31:0] pend_q [$];
  always @(posedge clk) begin
    if (reset) begin
      pend_q.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      if (imem_rsp_valid) void'(pend_q.pop_front());
      if (imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
      if (!mem_hold && pend_q.size() != 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(pend_q[0]);
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reset for two cycles, release one time unit after a rising edge with default inputs.
  task automatic do_reset();
    @(posedge clk); #1;
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    mem_hold       = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Wait (bounded) for a valid instruction at a falling edge; returns 1 if seen.
  task automatic wait_instr(input string name, output bit seen);
    int n = 0;
    @(negedge clk);
    while (instr_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    seen = (instr_valid === 1'b1);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: instr_valid never rose within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b1; mem_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    checks++;
    if (fetch_misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", fetch_misaligned); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL reset_first_req got valid=%b addr=%h exp valid=1 addr=00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    bit seen;
    logic [31:0] exp_pc;
    do_reset();
    wait_instr("stream", seen);
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(4 * i);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
        failures++;
        $display("FAIL stream_%0d got valid=%b pc=%h instr=%h exp valid=1 pc=%h instr=%h",
                 i, instr_valid, instr_pc, instr, exp_pc, mem_word(exp_pc));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    logic [31:0] addrs [4];
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) addrs[i] = 32'hDEAD_BEEF;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        if (nreq < 4) addrs[nreq] = imem_req_addr;
        nreq++;
      end
    end
    checks++;
    if (nreq != 4) begin failures++; $display("FAIL bp_req_count got=%0d exp=4", nreq); end
    checks++;
    if ({addrs[0], addrs[1], addrs[2], addrs[3]} !== {32'h0, 32'h4, 32'h8, 32'hC}) begin
      failures++;
      $display("FAIL bp_req_addrs got=%h,%h,%h,%h exp=0,4,8,c", addrs[0], addrs[1], addrs[2], addrs[3]);
    end
    checks++;
    if ({imem_req_valid, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL bp_full got req_valid=%b instr_valid=%b pc=%h exp 0,1,00000000", imem_req_valid, instr_valid, instr_pc);
    end
    @(posedge clk); #1 instr_ready = 1'b1;
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_pc, imem_req_valid, imem_req_addr} !== {32'h4, 1'b1, 32'h10}) begin
      failures++;
      $display("FAIL bp_after_pop got pc=%h req_valid=%b addr=%h exp pc=00000004 req_valid=1 addr=00000010",
               instr_pc, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
        failures++;
        $display("FAIL stall_hold_%0d got valid=%b addr=%h exp valid=1 addr=00000000", c, imem_req_valid, imem_req_addr);
      end
    end
    @(posedge clk); #1 imem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL stall_release got=%h exp=00000000", imem_req_addr); end
    @(negedge clk);
    checks++;
    if (imem_req_addr !== 32'h4) begin failures++; $display("FAIL stall_advance got=%h exp=00000004", imem_req_addr); end
  endtask

  task automatic test_redirect();
    bit seen;
    do_reset();
    mem_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    mem_hold       = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_valid, imem_req_valid} !== 2'b00) begin
      failures++;
      $display("FAIL redir_cycle got instr_valid=%b req_valid=%b exp 0,0", instr_valid, imem_req_valid);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL redir_req got valid=%b addr=%h exp valid=1 addr=00000100", imem_req_valid, imem_req_addr);
    end
    wait_instr("redir", seen);
    checks++;
    if ({instr_pc, instr} !== {32'h100, mem_word(32'h100)}) begin
      failures++;
      $display("FAIL redir_first_instr got pc=%h instr=%h exp pc=00000100 instr=%h", instr_pc, instr, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_during_discard();
    bit seen;
    do_reset();
    mem_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    mem_hold       = 1'b0;
    @(posedge clk); #1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    checks++;
    if ({imem_rsp_valid, instr_valid} !== 2'b10) begin
      failures++;
      $display("FAIL redir2_cycle got rsp_valid=%b instr_valid=%b exp 1,0", imem_rsp_valid, instr_valid);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    wait_instr("redir2", seen);
    checks++;
    if ({instr_pc, instr} !== {32'h300, mem_word(32'h300)}) begin
      failures++;
      $display("FAIL redir2_first_instr got pc=%h instr=%h exp pc=00000300 instr=%h", instr_pc, instr, mem_word(32'h300));
    end
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      failures++;
      $display("FAIL wrap_req0 got valid=%b addr=%h exp valid=1 addr=fffffffc", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL wrap_req1 got valid=%b addr=%h exp valid=1 addr=00000000", imem_req_valid, imem_req_addr);
    end
    wait_instr("wrap", seen);
    checks++;
    if (instr_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_instr0 got pc=%h exp=fffffffc", instr_pc); end
    @(negedge clk);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
      failures++;
      $display("FAIL wrap_instr1 got valid=%b pc=%h instr=%h exp valid=1 pc=00000000 instr=%h",
               instr_valid, instr_pc, instr, mem_word(32'h0));
    end
  endtask

  task automatic test_misalign();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({fetch_misaligned, imem_req_valid, imem_req_addr} !== {MIS_EXP, 1'b1, 32'h100}) begin
      failures++;
      $display("FAIL misalign_set got flag=%b valid=%b addr=%h exp flag=%b valid=1 addr=00000100",
               fetch_misaligned, imem_req_valid, imem_req_addr, MIS_EXP);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fetch_misaligned !== MIS_EXP) begin
      failures++;
      $display("FAIL misalign_sticky got=%b exp=%b", fetch_misaligned, MIS_EXP);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_misaligned !== 1'b0) begin failures++; $display("FAIL misalign_reset got=%b exp=0", fetch_misaligned); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_redirect();
    test_redirect_during_discard();
    test_wrap();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  response valid; responses in request order, no backpressure.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump taken, one-cycle pulse.
REQ-011 SHALL have port redirect_pc  input  32  new fetch target (PCTarget).
REQ-012 SHALL have port instr_valid  output  1  instruction available to datapath/decode.
REQ-013 SHALL have port instr_ready  input  1  consumer accepts instruction.
REQ-014 SHALL have port instr  output  32  instruction word at FIFO head.
REQ-015 SHALL have port instr_pc  output  32  PC of instr.
REQ-016 SHALL have port fetch_misaligned  output  1  sticky misaligned-redirect flag.

Function
REQ-017 Request handshake: transfer when imem_req_valid && imem_req_ready; fetch_pc += 4 per transfer.
REQ-018 imem_req_valid SHALL be 1 iff (fifo_count + outstanding) < FIFO_DEPTH and redirect_valid == 0; imem_req_addr = fetch_pc.
REQ-019 outstanding counter (width clog2(FIFO_DEPTH)+1): +1 per request transfer, -1 per imem_rsp_valid, both same cycle -> unchanged.
REQ-020 Non-discarded response SHALL push {imem_rsp_data, rsp_pc} into FIFO and rsp_pc += 4; credit rule guarantees no overflow.
REQ-021 instr/instr_pc SHALL reflect FIFO head; instr_valid = !empty && !redirect_valid; pop on instr_valid && instr_ready.
REQ-022 Push and pop in same cycle SHALL leave count unchanged; push into empty FIFO visible as instr_valid next cycle (1-cycle response-to-instr latency).
REQ-023 Redirect cycle: FIFO flushed, fetch_pc <= redirect_pc, rsp_pc <= redirect_pc, discard_cnt <= outstanding - imem_rsp_valid; response arriving that cycle dropped.
REQ-024 While discard_cnt > 0, each imem_rsp_valid SHALL be dropped and discard_cnt decremented; no FIFO push, rsp_pc unchanged.
REQ-025 Redirect while discard_cnt > 0 SHALL reload discard_cnt per REQ-023 (outstanding already includes prior stale requests).
REQ-026 fetch_pc/rsp_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-027 redirect_pc[1:0] SHALL be ignored for addressing (imem_req_addr[1:0] = 2'b00 always).

Reset
REQ-028 Reset assertion SHALL immediately set fetch_pc = rsp_pc = RESET_PC, FIFO empty, outstanding = discard_cnt = 0, fetch_misaligned = 0.
REQ-029 During reset imem_req_valid = 0 and instr_valid = 0; first request at RESET_PC in first cycle after deassertion.
REQ-030 Responses to requests issued before a mid-operation reset are the memory's responsibility; fetch_unit assumes none arrive after reset.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN defined: fetch_misaligned set when redirect_valid && redirect_pc[1:0] != 0, cleared only by reset.
REQ-032 Macro undefined: fetch_misaligned tied 0, no check logic; all other behaviour identical.

Verification
REQ-033 Reset, imem_req_ready=1, 1-cycle memory, instr_ready=1 -> instr_pc sequence 0,4,8,12, one instr per cycle after fill.
REQ-034 instr_ready=0, FIFO_DEPTH=4 -> exactly 4 requests (0x0..0xC), imem_req_valid low until a pop.
REQ-035 3 outstanding, redirect_pc=0x100 -> 3 stale responses dropped, next instr_pc=0x100, instr_valid=0 in redirect cycle.
REQ-036 imem_req_ready=0 for 5 cycles -> imem_req_valid/addr held stable, no fetch_pc advance.
REQ-037 Redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-038 FETCH_MISALIGN_CHECK_EN, redirect_pc=0x102 -> fetch_misaligned=1 next cycle, stays 1, imem_req_addr=0x100; reset clears it.
